// File: rtl/pmod_i2s_scheduler.sv
// Round-robin arbiter sharing the PmodI2S shifter between alarm tone (0) and key beep (1).
// Optional I2S_SCHED_SILENCE_EN: idle slots send a zero sample so the DAC sees continuous frames.
module pmod_i2s_scheduler #(
    parameter int FRAME_LEN = 32,
    parameter int DW        = 16
) (
    input  logic          clk_sclk,
    input  logic          rst,
    input  logic          i2s_en,
    input  logic [1:0]    req,
    input  logic [DW-1:0] sample0,
    input  logic [DW-1:0] sample1,
    output logic [1:0]    ack,
    input  logic          cntr_ncs,
    output logic          start,
    output logic [DW-1:0] tx_data,
    output logic          lrck,
    output logic          busy,
    output logic [7:0]    missed_cnt
);

    localparam int FC_W = $clog2(FRAME_LEN);
    localparam logic [FC_W-1:0] LAST_CNT = FC_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_SHIFT,
        WAIT_DONE,
        RELEASE
    } state_t;

    state_t          state_reg, state_next;
    logic [FC_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic            lrck_reg, lrck_next;
    logic            rr_ptr_reg, rr_ptr_next;
    logic            winner_reg, winner_next;
    logic            silence_reg, silence_next;
    logic            start_reg, start_next;
    logic            busy_reg, busy_next;
    logic [DW-1:0]   tx_data_reg, tx_data_next;
    logic [1:0]      ack_reg, ack_next;
    logic [7:0]      missed_reg, missed_next;

    logic slot_tick;
    logic pick;
    logic done_now;

    assign slot_tick = (frame_cnt_reg == LAST_CNT);
    // Contention goes to rr_ptr; a lone requester always wins.
    assign pick      = (req == 2'b11) ? rr_ptr_reg : req[1];
    assign done_now  = (state_reg == WAIT_DONE) && cntr_ncs;

    // The ack is decoded per requester; silence transfers never acknowledge anyone.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_next[gi] = done_now && !silence_reg && (winner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = slot_tick ? '0 : frame_cnt_reg + 1'b1;
        lrck_next      = slot_tick ? ~lrck_reg : lrck_reg;
        rr_ptr_next    = rr_ptr_reg;
        winner_next    = winner_reg;
        silence_next   = silence_reg;
        start_next     = start_reg;
        busy_next      = busy_reg;
        tx_data_next   = tx_data_reg;
        missed_next    = missed_reg;

        case (state_reg)
            IDLE: begin
                // Outputs are registered, so the winner and its sample are captured on entry to GRANT.
                if (slot_tick && i2s_en) begin
                    if (|req) begin
                        state_next   = GRANT;
                        winner_next  = pick;
                        silence_next = 1'b0;
                        tx_data_next = pick ? sample1 : sample0;
                        start_next   = 1'b1;
                        busy_next    = 1'b1;
                    end
`ifdef I2S_SCHED_SILENCE_EN
                    else begin
                        state_next   = GRANT;
                        silence_next = 1'b1;
                        tx_data_next = '0;
                        start_next   = 1'b1;
                        busy_next    = 1'b1;
                    end
`endif
                end
            end
            GRANT: begin
                state_next = WAIT_SHIFT;
            end
            WAIT_SHIFT: begin
                if (!cntr_ncs) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cntr_ncs) begin
                    state_next = RELEASE;
                    start_next = 1'b0;
                    if (!silence_reg) begin
                        rr_ptr_next = ~winner_reg;
                    end
                end
            end
            RELEASE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                start_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase

        // A slot boundary reached while the shifter is still busy loses that slot.
        if (slot_tick && (state_reg == WAIT_SHIFT || state_reg == WAIT_DONE) && missed_reg != 8'hFF) begin
            missed_next = missed_reg + 8'd1;
        end
    end

    always_ff @(negedge clk_sclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= '0;
            lrck_reg      <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            winner_reg    <= 1'b0;
            silence_reg   <= 1'b0;
            start_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            tx_data_reg   <= '0;
            ack_reg       <= 2'b00;
            missed_reg    <= 8'd0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            lrck_reg      <= lrck_next;
            rr_ptr_reg    <= rr_ptr_next;
            winner_reg    <= winner_next;
            silence_reg   <= silence_next;
            start_reg     <= start_next;
            busy_reg      <= busy_next;
            tx_data_reg   <= tx_data_next;
            ack_reg       <= ack_next;
            missed_reg    <= missed_next;
        end
    end

    assign ack        = ack_reg;
    assign start      = start_reg;
    assign tx_data    = tx_data_reg;
    assign lrck       = lrck_reg;
    assign busy       = busy_reg;
    assign missed_cnt = missed_reg;

endmodule
